pipelined_add_sub: RTL and testbench

//   Parametrised, pipelined two's-complement adder/subtractor with carry-in, carry-out
//   and signed-overflow flags. Operand width splits into STAGES equal slices. Each slice

---
 rtl/pipelined_add_sub.sv | 78 +++++++
 tb/tb_pipelined_add_sub.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub: carry-segmented pipelined adder/subtractor with valid/ready handshake
module pipelined_add_sub #(
  parameter int DATA_WIDTH = 8,
  parameter int STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  sub,
  input  logic                  cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  cout,
  output logic                  overflow
);
  localparam int SLICE = DATA_WIDTH / STAGES;
  logic en, c, cm_n, cm_q;
  logic [STAGES-1:0] v_i, v_q, c_i, c_n, c_q;
  logic [DATA_WIDTH-1:0] a_i [STAGES], b_i [STAGES], s_i [STAGES], s_n [STAGES];
  logic [DATA_WIDTH-1:0] a_q [STAGES], b_q [STAGES], s_q [STAGES];
  assign en = out_ready | ~out_valid;
  assign in_ready = en;
  assign out_valid = v_q[STAGES-1];
  assign sum = s_q[STAGES-1];
  assign cout = c_q[STAGES-1];
  assign overflow = cm_q ^ c_q[STAGES-1];
  assign a_i[0] = a;
  assign b_i[0] = sub ? ~b : b;
  assign s_i[0] = '0;
  assign c_i[0] = sub ^ cin;
  assign v_i[0] = in_valid;
  for (genvar k = 1; k < STAGES; k++) begin : g_link
    assign a_i[k] = a_q[k-1];
    assign b_i[k] = b_q[k-1];
    assign s_i[k] = s_q[k-1];
    assign c_i[k] = c_q[k-1];
    assign v_i[k] = v_q[k-1];
  end
  // Stage k ripples slice k only; finished lower slices and pending upper operands pass through.
  always_comb begin
    cm_n = 1'b0;
    c = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      s_n[k] = s_i[k];
      c = c_i[k];
      for (int i = k * SLICE; i < (k + 1) * SLICE; i++) begin
        cm_n = (i == DATA_WIDTH - 1) ? c : cm_n;
        s_n[k][i] = a_i[k][i] ^ b_i[k][i] ^ c;
        c = (a_i[k][i] & b_i[k][i]) | (c & (a_i[k][i] ^ b_i[k][i]));
      end
      c_n[k] = c;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      v_q <= '0;
      c_q <= '0;
      cm_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (en) begin
      v_q <= v_i;
      c_q <= c_n;
      cm_q <= cm_n;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_i[k];
        b_q[k] <= b_i[k];
        s_q[k] <= s_n[k];
      end
    end
endmodule

// File: tb/tb_pipelined_add_sub.sv
// tb_pipelined_add_sub: directed and randomized checks of pipelined_add_sub at STAGES 2,1,4,8
module tb_pipelined_add_sub;
  logic clk = 1'b0;
  logic rst, in_valid, sub, cin;
  logic [7:0] a, b;
  logic [3:0] out_ready, in_ready, out_valid, cout, overflow;
  logic [7:0] sum [4];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // instance 0 is STAGES=2 (directed tests); 1..3 are STAGES 1,4,8
  for (genvar g = 0; g < 4; g++) begin : g_dut
    pipelined_add_sub #(
      .DATA_WIDTH(8),
      .STAGES(g == 0 ? 2 : g == 1 ? 1 : g == 2 ? 4 : 8)
    ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[g]),
      .a(a), .b(b), .sub(sub), .cin(cin),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .sum(sum[g]), .cout(cout[g]), .overflow(overflow[g])
    );
  end

  // {overflow, cout, sum} from integer arithmetic on the operand values
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic s, input logic c);
    int ux, uy, sx, sy, ur, sr;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    ur = s ? ux - uy - int'(c) : ux + uy + int'(c);
    sr = s ? sx - sy - int'(c) : sx + sy + int'(c);
    return {(sr > 127) || (sr < -128), s ? (ur >= 0) : (ur > 255), 8'(ur)};
  endfunction

  // one beat into the pipe; mid = out_valid[0] one edge after acceptance; returns two edges later
  task automatic beat(input logic [7:0] x, input logic [7:0] y, input logic s, input logic c, output logic mid);
    @(negedge clk);
    in_valid = 1'b1; a = x; b = y; sub = s; cin = c;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    mid = out_valid[0];
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = '1; a = 8'hAA; b = 8'h55; sub = 1'b0; cin = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 4'h0 || in_ready !== 4'hF || cout !== 4'h0 || overflow !== 4'h0) begin
      failures++;
      $display("FAIL reset_flags: valid=%b ready=%b cout=%b ovf=%b, required 0000 1111 0000 0000", out_valid, in_ready, cout, overflow);
    end
    checks++;
    if (sum[0] !== 8'h0 || sum[1] !== 8'h0 || sum[2] !== 8'h0 || sum[3] !== 8'h0) begin
      failures++;
      $display("FAIL reset_sum: %h %h %h %h, required all 00", sum[0], sum[1], sum[2], sum[3]);
    end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_add();
    logic mid;
    beat(8'h7F, 8'h01, 1'b0, 1'b0, mid);
    checks++;
    if (mid !== 1'b0 || out_valid[0] !== 1'b1) begin
      failures++;
      $display("FAIL add_latency: valid after 1 edge=%b after 2 edges=%b, required 0 then 1", mid, out_valid[0]);
    end
    checks++;
    if ({overflow[0], cout[0], sum[0]} !== 10'h280) begin
      failures++;
      $display("FAIL add_7F_01: got %h, required 280", {overflow[0], cout[0], sum[0]});
    end
  endtask

  task automatic test_carry();
    logic mid;
    beat(8'hFF, 8'h01, 1'b0, 1'b0, mid);
    checks++;
    if (out_valid[0] !== 1'b1 || {overflow[0], cout[0], sum[0]} !== 10'h100) begin
      failures++;
      $display("FAIL carry_FF_01: valid=%b got %h, required 1 100", out_valid[0], {overflow[0], cout[0], sum[0]});
    end
    beat(8'h0F, 8'hF0, 1'b0, 1'b1, mid);
    checks++;
    if (out_valid[0] !== 1'b1 || {overflow[0], cout[0], sum[0]} !== 10'h100) begin
      failures++;
      $display("FAIL carry_0F_F0_cin: valid=%b got %h, required 1 100", out_valid[0], {overflow[0], cout[0], sum[0]});
    end
  endtask

  task automatic test_sub();
    logic mid;
    beat(8'h05, 8'h07, 1'b1, 1'b0, mid);
    checks++;
    if ({overflow[0], cout[0], sum[0]} !== 10'h0FE) begin
      failures++;
      $display("FAIL sub_05_07: got %h, required 0FE", {overflow[0], cout[0], sum[0]});
    end
    beat(8'h80, 8'h01, 1'b1, 1'b0, mid);
    checks++;
    if ({overflow[0], cout[0], sum[0]} !== 10'h37F) begin
      failures++;
      $display("FAIL sub_80_01: got %h, required 37F", {overflow[0], cout[0], sum[0]});
    end
    beat(8'h10, 8'h01, 1'b1, 1'b1, mid);
    checks++;
    if ({overflow[0], cout[0], sum[0]} !== 10'h10E) begin
      failures++;
      $display("FAIL sub_10_01_borrow: got %h, required 10E", {overflow[0], cout[0], sum[0]});
    end
  endtask

  task automatic test_stream();
    logic [9:0] want [6];
    logic [7:0] xa [6], xb [6];
    logic xs [6], xc [6];
    logic [9:0] snap;
    logic stalled;
    int sent, rcv;
    sent = 0; rcv = 0; stalled = 1'b0; snap = '0;
    for (int i = 0; i < 6; i++) begin
      xa[i] = 8'($urandom); xb[i] = 8'($urandom); xs[i] = 1'($urandom); xc[i] = 1'($urandom);
      want[i] = model(xa[i], xb[i], xs[i], xc[i]);
    end
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      out_ready[0] = !(t >= 3 && t < 6);
      in_valid = sent < 6;
      if (sent < 6) begin
        a = xa[sent]; b = xb[sent]; sub = xs[sent]; cin = xc[sent];
      end
      #1;
      if (out_valid[0] && !out_ready[0]) begin
        checks++;
        if (in_ready[0] !== 1'b0) begin
          failures++;
          $display("FAIL stall_ready: in_ready=%b at cycle %0d, required 0", in_ready[0], t);
        end
        if (stalled) begin
          checks++;
          if ({overflow[0], cout[0], sum[0]} !== snap) begin
            failures++;
            $display("FAIL stall_frozen: got %h, required %h at cycle %0d", {overflow[0], cout[0], sum[0]}, snap, t);
          end
        end
        snap = {overflow[0], cout[0], sum[0]};
        stalled = 1'b1;
      end else stalled = 1'b0;
      if (out_valid[0] && out_ready[0]) begin
        checks++;
        if (rcv >= 6) begin
          failures++;
          $display("FAIL stream_extra: beat %0d got %h, required no beat", rcv, {overflow[0], cout[0], sum[0]});
        end else if ({overflow[0], cout[0], sum[0]} !== want[rcv]) begin
          failures++;
          $display("FAIL stream_order: beat %0d got %h, required %h", rcv, {overflow[0], cout[0], sum[0]}, want[rcv]);
        end
        rcv++;
      end
      if (in_valid && in_ready[0]) sent++;
    end
    in_valid = 1'b0; out_ready[0] = 1'b1;
    checks++;
    if (rcv != 6) begin
      failures++;
      $display("FAIL stream_count: delivered %0d, required 6", rcv);
    end
  endtask

  task automatic test_flush();
    logic mid;
    int seen;
    @(negedge clk);
    out_ready[0] = 1'b0; in_valid = 1'b1; a = 8'h11; b = 8'h22; sub = 1'b0; cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a = 8'h33; b = 8'h44;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid[0] !== 1'b1 || sum[0] !== 8'h33) begin
      failures++;
      $display("FAIL flush_pre: valid=%b sum=%h, required 1 33", out_valid[0], sum[0]);
    end
    rst = 1'b1; a = 8'h55; b = 8'h66;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready[0] = 1'b1;
    #1;
    checks++;
    if (out_valid[0] !== 1'b0 || sum[0] !== 8'h0 || cout[0] !== 1'b0 || overflow[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      failures++;
      $display("FAIL flush_reset: valid=%b sum=%h cout=%b ovf=%b ready=%b, required 0 00 0 0 1",
               out_valid[0], sum[0], cout[0], overflow[0], in_ready[0]);
    end
    seen = 0;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      if (out_valid[0]) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL flush_ghost: %0d valid cycles after reset, required 0", seen);
    end
    beat(8'h12, 8'h34, 1'b0, 1'b1, mid);
    checks++;
    if (mid !== 1'b0 || out_valid[0] !== 1'b1 || {overflow[0], cout[0], sum[0]} !== 10'h047) begin
      failures++;
      $display("FAIL flush_next: mid=%b valid=%b got %h, required 0 1 047", mid, out_valid[0], {overflow[0], cout[0], sum[0]});
    end
  endtask

  task automatic test_random();
    logic [9:0] mem [4][32];
    int wp [4], rp [4];
    logic [9:0] got;
    for (int d = 0; d < 4; d++) begin
      wp[d] = 0; rp[d] = 0;
    end
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = '1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 10020; n++) begin
      @(negedge clk);
      in_valid = (n < 10000) && ($urandom_range(0, 3) != 0);
      a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      for (int d = 0; d < 4; d++) out_ready[d] = (n >= 10000) || ($urandom_range(0, 3) != 0);
      #1;
      for (int d = 0; d < 4; d++) begin
        checks++;
        if (in_ready[d] !== (out_ready[d] | ~out_valid[d])) begin
          failures++;
          if (failures < 20) $display("FAIL rand_ready[%0d]: in_ready=%b, required %b", d, in_ready[d], out_ready[d] | ~out_valid[d]);
        end
        if (out_valid[d] && out_ready[d]) begin
          got = {overflow[d], cout[d], sum[d]};
          checks++;
          if (rp[d] == wp[d]) begin
            failures++;
            if (failures < 20) $display("FAIL rand_spurious[%0d]: got %h, required no beat", d, got);
          end else begin
            if (got !== mem[d][rp[d] % 32]) begin
              failures++;
              if (failures < 20) $display("FAIL rand_result[%0d]: beat %0d got %h, required %h", d, rp[d], got, mem[d][rp[d] % 32]);
            end
            rp[d]++;
          end
        end
        if (in_valid && in_ready[d]) begin
          mem[d][wp[d] % 32] = model(a, b, sub, cin);
          wp[d]++;
        end
      end
    end
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (rp[d] != wp[d] || wp[d] < 1000) begin
        failures++;
        $display("FAIL rand_drain[%0d]: delivered %0d of %0d accepted, required all (and over 1000)", d, rp[d], wp[d]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_carry();
    test_sub();
    test_stream();
    test_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
